// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Logic, shift and add-class ops finish in one
// cycle; signed mul/div iterate one bit per cycle on operand magnitudes,
// then apply sign correction in a final FIX cycle.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     ry,
  input  logic [WIDTH-1:0]     rb,
  input  logic                 branch_flag,
  output logic [2*WIDTH-1:0]   c_out,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  // Single-cycle result; HI is zero for all defined ops, all ones otherwise.
  function automatic logic [2*WIDTH-1:0] alu_single(
    input logic [4:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             bf
  );
    logic [WIDTH-1:0]   res;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rot;
    logic               valid;
    amt   = b[SHW-1:0];
    dbl   = {a, a};
    rot   = '0;
    res   = '0;
    valid = 1'b1;
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_JR,
      OP_ADD, OP_ADDI: res = a + b;
      OP_JAL:          res = a + b + WIDTH'(1);
      OP_SUB:          res = a - b;
      OP_SHR:          res = a >> amt;
      OP_SHRA:         res = $unsigned($signed(a) >>> amt);
      OP_SHL:          res = a << amt;
      OP_ROR: begin
        rot = dbl >> amt;
        res = rot[WIDTH-1:0];
      end
      OP_ROL: begin
        rot = dbl << amt;
        res = rot[2*WIDTH-1:WIDTH];
      end
      OP_AND, OP_ANDI: res = a & b;
      OP_OR, OP_ORI:   res = a | b;
      OP_NEG:          res = WIDTH'(0) - b;
      OP_NOT:          res = ~b;
      OP_BR:           res = bf ? (a + b) : a;
      default:         valid = 1'b0;
    endcase
    if (valid) begin
      alu_single = {{WIDTH{1'b0}}, res};
    end else begin
      alu_single = {(2*WIDTH){1'b1}};
    end
  endfunction

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;      // mul: product high half / div: remainder
  logic [WIDTH-1:0]     lo_q, lo_d;      // mul: multiplier / div: dividend -> quotient
  logic [WIDTH-1:0]     opnd_q, opnd_d;  // mul: multiplicand / div: divisor
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 is_div_q, is_div_d;
  logic [2*WIDTH-1:0]   c_out_q, c_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  // Magnitudes as unsigned WIDTH bits: 2^(WIDTH-1) is representable exactly.
  logic [WIDTH-1:0]     mag_a_s, mag_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH-1:0]     div_shift_s, div_diff_s;
  logic                 div_ge_s;
  logic [2*WIDTH-1:0]   prod_s, mul_res_s;
  logic [WIDTH-1:0]     quo_res_s, rem_res_s;

  assign mag_a_s     = ry[WIDTH-1] ? (WIDTH'(0) - ry) : ry;
  assign mag_b_s     = rb[WIDTH-1] ? (WIDTH'(0) - rb) : rb;
  assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // Remainder stays below the divisor (<= 2^(WIDTH-1)), so the shifted value fits WIDTH bits.
  assign div_shift_s = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= opnd_q);
  assign div_diff_s  = div_shift_s - opnd_q;
  assign prod_s      = {hi_q, lo_q};
  assign mul_res_s   = (sign_a_q ^ sign_b_q) ? ((2*WIDTH)'(0) - prod_s) : prod_s;
  assign quo_res_s   = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - lo_q) : lo_q;
  assign rem_res_s   = sign_a_q ? (WIDTH'(0) - hi_q) : hi_q;

  // Next-state and datapath control for the IDLE/CALC/FIX sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    is_div_d   = is_div_q;
    c_out_d    = c_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL || (opcode == OP_DIV && rb != WIDTH'(0))) begin
            state_d  = S_CALC;
            busy_d   = 1'b1;
            cnt_d    = '0;
            sign_a_d = ry[WIDTH-1];
            sign_b_d = rb[WIDTH-1];
            is_div_d = (opcode == OP_DIV);
            hi_d     = '0;
            if (opcode == OP_DIV) begin
              lo_d   = mag_a_s;
              opnd_d = mag_b_s;
            end else begin
              lo_d   = mag_b_s;
              opnd_d = mag_a_s;
            end
          end else if (opcode == OP_DIV) begin
            // Divide by zero completes immediately with a flagged result.
            c_out_d    = {ry, {WIDTH{1'b1}}};
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            c_out_d    = alu_single(opcode, ry, rb, branch_flag);
            div_zero_d = 1'b0;
            done_d     = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + SHW'(1);
          if (is_div_q) begin
            hi_d = div_ge_s ? div_diff_s : div_shift_s;
            lo_d = {lo_q[WIDTH-2:0], div_ge_s};
          end else begin
            hi_d = mul_sum_s[WIDTH:1];
            lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (abort) begin
          done_d = 1'b0;
        end else begin
          if (is_div_q) begin
            c_out_d = {rem_res_s, quo_res_s};
          end else begin
            c_out_d = mul_res_s;
          end
          div_zero_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; async reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      is_div_q   <= 1'b0;
      c_out_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      is_div_q   <= is_div_d;
      c_out_q    <= c_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign c_out    = c_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=32): table of single-cycle vectors
// plus hand sequences for mul/div latency, div-by-zero, abort and reset.
module tb_seq_alu;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [4:0]     opcode = 5'b00000;
  logic [W-1:0]   ry = '0;
  logic [W-1:0]   rb = '0;
  logic           branch_flag = 1'b0;
  logic [2*W-1:0] c_out;
  logic           busy;
  logic           done;
  logic           div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .opcode(opcode),
    .ry(ry), .rb(rb), .branch_flag(branch_flag),
    .c_out(c_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           bf;
    logic [2*W-1:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one start pulse; returns at the negedge after the sampling edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic bf);
    @(negedge clk);
    opcode = op; ry = a; rb = b; branch_flag = bf; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Multi-cycle op: checks done latency, busy length, result, single-pulse done.
  task automatic run_long(input string nm, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int k;
    int busy_cnt;
    bit seen;
    issue(op, a, b, 1'b0);
    k = 0; busy_cnt = 0; seen = 1'b0;
    while (k < 60 && !seen) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (k == 5) begin
          start = 1'b1; opcode = 5'b00011; ry = 32'h1; rb = 32'h1;
        end
        if (k == 6) start = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    check({nm, " done latency"}, 64'(k), 64'd33);
    check({nm, " busy cycles"}, 64'(busy_cnt), 64'd33);
    check({nm, " result"}, c_out, exp);
    @(negedge clk);
    check({nm, " done single pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int k;
    int n_done;

    vecs[0]  = '{5'b00011, 32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h0000000000000001}; // add wrap
    vecs[1]  = '{5'b01000, 32'h80000001, 32'h00000001, 1'b0, 64'h00000000C0000000}; // ror
    vecs[2]  = '{5'b00110, 32'h80000000, 32'h00000004, 1'b0, 64'h00000000F8000000}; // shra
    vecs[3]  = '{5'b10011, 32'h00000100, 32'h00000020, 1'b0, 64'h0000000000000100}; // br not taken
    vecs[4]  = '{5'b10011, 32'h00000100, 32'h00000020, 1'b1, 64'h0000000000000120}; // br taken
    vecs[5]  = '{5'b10101, 32'h00000005, 32'h00000006, 1'b0, 64'h000000000000000C}; // jal
    vecs[6]  = '{5'b00100, 32'h00000003, 32'h00000005, 1'b0, 64'h00000000FFFFFFFE}; // sub
    vecs[7]  = '{5'b00111, 32'h00000001, 32'h0000001F, 1'b0, 64'h0000000080000000}; // shl 31
    vecs[8]  = '{5'b00101, 32'h80000000, 32'h0000001F, 1'b0, 64'h0000000000000001}; // shr 31
    vecs[9]  = '{5'b01001, 32'h80000001, 32'h00000001, 1'b0, 64'h0000000000000003}; // rol
    vecs[10] = '{5'b01010, 32'h0000F0F0, 32'h0000FF00, 1'b0, 64'h000000000000F000}; // and
    vecs[11] = '{5'b01110, 32'h0000F0F0, 32'h0000FF00, 1'b0, 64'h000000000000FFF0}; // ori
    vecs[12] = '{5'b10001, 32'h12345678, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF}; // neg
    vecs[13] = '{5'b10010, 32'h12345678, 32'h0F0F0F0F, 1'b0, 64'h00000000F0F0F0F0}; // not
    vecs[14] = '{5'b11111, 32'h00000001, 32'h00000001, 1'b0, 64'hFFFFFFFFFFFFFFFF}; // undefined
    vecs[15] = '{5'b00111, 32'h00000001, 32'h00000021, 1'b0, 64'h0000000000000002}; // shl uses rb[4:0]

    // Reset state
    repeat (2) @(negedge clk);
    check("reset c_out", c_out, 64'h0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    rst_n = 1'b1;

    // Single-cycle table
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].bf);
      check($sformatf("vec%0d done", i), 64'(done), 64'd1);
      check($sformatf("vec%0d c_out", i), c_out, vecs[i].exp);
    end

    // c_out holds between completions, done drops
    @(negedge clk);
    check("hold c_out", c_out, 64'h0000000000000002);
    check("done dropped", 64'(done), 64'd0);

    // Back-to-back single-cycle ops with start held high
    @(negedge clk);
    opcode = 5'b00011; ry = 32'd10; rb = 32'd20; start = 1'b1;
    @(negedge clk);
    check("b2b first", c_out, 64'd30);
    opcode = 5'b00100; ry = 32'd10; rb = 32'd20;
    @(negedge clk);
    start = 1'b0;
    check("b2b second", c_out, 64'h00000000FFFFFFF6);
    check("b2b second done", 64'(done), 64'd1);

    // Async reset mid-cycle clears c_out immediately
    #2 rst_n = 1'b0;
    #1 check("async reset c_out", c_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multi-cycle mul/div
    run_long("mul -3*7", 5'b01111, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB);
    run_long("mul minneg^2", 5'b01111, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run_long("div -7/2", 5'b10000, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFFFFFFFFFD);
    run_long("div minneg/-1", 5'b10000, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000);
    run_long("div 100/7", 5'b10000, 32'd100, 32'd7, 64'h000000020000000E);

    // Divide by zero, then a following op clears the flag
    issue(5'b10000, 32'h00000005, 32'h00000000, 1'b0);
    check("div0 done", 64'(done), 64'd1);
    check("div0 c_out", c_out, 64'h00000005FFFFFFFF);
    check("div0 flag", 64'(div_zero), 64'd1);
    @(negedge clk);
    check("div0 flag holds", 64'(div_zero), 64'd1);
    issue(5'b00011, 32'd1, 32'd1, 1'b0);
    check("div0 cleared by add", 64'(div_zero), 64'd0);

    // Abort mid-mul: no done, c_out kept, next start accepted right after
    issue(5'b00011, 32'd2, 32'd3, 1'b0);
    issue(5'b01111, 32'd9, 32'd9, 1'b0);
    n_done = 0;
    for (k = 0; k < 10; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort c_out kept", c_out, 64'd5);
    opcode = 5'b00011; ry = 32'd4; rb = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post-abort start done", 64'(done), 64'd1);
    check("post-abort start c_out", c_out, 64'd8);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no late done", 64'(n_done), 64'd0);

    // Reset mid-mul: all outputs zero, no done afterwards
    issue(5'b10000, 32'd5, 32'd0, 1'b0);
    issue(5'b01111, 32'd9, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid-mul c_out", c_out, 64'h0);
    check("rst mid-mul busy", 64'(busy), 64'd0);
    check("rst mid-mul done", 64'(done), 64'd0);
    check("rst mid-mul div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst no late done", 64'(n_done), 64'd0);
    check("rst busy stays low", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
